// File: rtl/matvec_param.sv
// matvec_param: streaming signed matrix-vector multiply y = W*x, W is N x N, reused until new_matrix.
// Latency: last x beat at edge t -> row 0 valid at edge t+N+1; each later row N+1 cycles after the previous out beat.
// Backpressure: input stalls on gaps in input_valid; output row held stable until output_ready; no input accepted until IDLE.
// Ports:
//   clk, reset                       rising-edge clock, asynchronous active-high reset
//   input_valid/input_ready/input_data/new_matrix   element stream (W row-major, then x)
//   output_valid/output_ready/output_data/output_last/output_sat   one y row per beat
module matvec_param #(
    parameter int N        = 3,
    parameter int IW       = 14,
    parameter int OW       = 28,
    parameter int SATURATE = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 input_valid,
    output logic                 input_ready,
    input  logic signed [IW-1:0] input_data,
    input  logic                 new_matrix,
    output logic                 output_valid,
    input  logic                 output_ready,
    output logic signed [OW-1:0] output_data,
    output logic                 output_last,
    output logic                 output_sat
);

    localparam int AW = 2*IW + $clog2(N) + 1;   // accumulator width, never overflows
    localparam int NN = N*N;
    localparam int CW = $clog2(NN);             // load counter, 0..NN-1
    localparam int KW = $clog2(N+1);            // MAC step, 0..N
    localparam int RW = $clog2(N);              // row / column index, 0..N-1
    localparam bit CAN_CLAMP = (SATURATE != 0) && (OW < AW);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_W, S_LOAD_X, S_COMPUTE, S_OUTPUT
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [RW-1:0]          row_q, row_d;
    logic [KW-1:0]          k_q, k_d;
    logic signed [AW-1:0]   acc_q, acc_d;
    logic signed [2*IW-1:0] prod_q, prod_d;
    logic                   w_loaded_q, w_loaded_d;
    logic signed [OW-1:0]   data_q, data_d;
    logic                   last_q, last_d;
    logic                   sat_q, sat_d;

    logic signed [IW-1:0]   w_mem [NN];
    logic signed [IW-1:0]   x_mem [N];
    logic                   w_we, x_we;
    logic [CW-1:0]          wr_idx;

    logic                   beat;
    logic [RW-1:0]          k_rd;
    logic [CW-1:0]          w_rd_idx;
    logic signed [2*IW-1:0] mul;
    logic signed [AW-1:0]   acc_sum;
    logic signed [OW-1:0]   res;
    logic                   res_sat;

    assign input_ready  = (state_q == S_IDLE) || (state_q == S_LOAD_W) || (state_q == S_LOAD_X);
    assign output_valid = (state_q == S_OUTPUT);
    assign output_data  = data_q;
    assign output_last  = last_q;
    assign output_sat   = sat_q;
    assign beat         = input_valid && input_ready;

    // The MAC is split into a registered multiply and an accumulate one cycle
    // later, so a row takes N+1 COMPUTE cycles: the last one only adds the
    // final product and produces the result.
    assign k_rd     = (k_q < KW'(N)) ? k_q[RW-1:0] : '0;
    assign w_rd_idx = CW'(row_q) * CW'(N) + CW'(k_rd);
    assign mul      = w_mem[w_rd_idx] * x_mem[k_rd];
    assign acc_sum  = acc_q + AW'(prod_q);

    generate
        if (OW < AW) begin : g_narrow
            logic ovf;
            // Overflow when the bits above the OW sign bit are not all copies of it.
            assign ovf = !((&acc_sum[AW-1:OW-1]) || !(|acc_sum[AW-1:OW-1]));
            always_comb begin
                res     = acc_sum[OW-1:0];
                res_sat = 1'b0;
                if (CAN_CLAMP && ovf) begin
                    res     = acc_sum[AW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
                    res_sat = 1'b1;
                end
            end
        end else begin : g_wide
            assign res     = OW'(acc_sum);
            assign res_sat = 1'b0;
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        row_d      = row_q;
        k_d        = k_q;
        acc_d      = acc_q;
        prod_d     = prod_q;
        w_loaded_d = w_loaded_q;
        data_d     = data_q;
        last_d     = last_q;
        sat_d      = sat_q;
        w_we       = 1'b0;
        x_we       = 1'b0;
        wr_idx     = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (beat) begin
                    wr_idx = '0;
                    cnt_d  = CW'(1);
                    // new_matrix only matters on the first beat; an unloaded W forces a load.
                    if (new_matrix || !w_loaded_q) begin
                        w_we    = 1'b1;
                        state_d = S_LOAD_W;
                    end else begin
                        x_we    = 1'b1;
                        state_d = S_LOAD_X;
                    end
                end
            end
            S_LOAD_W: begin
                if (beat) begin
                    w_we = 1'b1;
                    if (cnt_q == CW'(NN-1)) begin
                        w_loaded_d = 1'b1;
                        cnt_d      = '0;
                        state_d    = S_LOAD_X;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_LOAD_X: begin
                if (beat) begin
                    x_we = 1'b1;
                    if (cnt_q == CW'(N-1)) begin
                        cnt_d   = '0;
                        row_d   = '0;
                        k_d     = '0;
                        acc_d   = '0;
                        prod_d  = '0;
                        state_d = S_COMPUTE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_COMPUTE: begin
                acc_d = acc_sum;
                if (k_q == KW'(N)) begin
                    data_d  = res;
                    sat_d   = res_sat;
                    last_d  = (row_q == RW'(N-1));
                    state_d = S_OUTPUT;
                end else begin
                    prod_d = mul;
                    k_d    = k_q + KW'(1);
                end
            end
            S_OUTPUT: begin
                if (output_ready) begin
                    if (row_q == RW'(N-1)) begin
                        state_d = S_IDLE;
                    end else begin
                        row_d   = row_q + RW'(1);
                        k_d     = '0;
                        acc_d   = '0;
                        prod_d  = '0;
                        state_d = S_COMPUTE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            row_q      <= '0;
            k_q        <= '0;
            acc_q      <= '0;
            prod_q     <= '0;
            w_loaded_q <= 1'b0;
            data_q     <= '0;
            last_q     <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            row_q      <= row_d;
            k_q        <= k_d;
            acc_q      <= acc_d;
            prod_q     <= prod_d;
            w_loaded_q <= w_loaded_d;
            data_q     <= data_d;
            last_q     <= last_d;
            sat_q      <= sat_d;
        end
    end

    // Operand storage is never read before it has been written, so it has no reset.
    always_ff @(posedge clk) begin
        if (w_we) w_mem[wr_idx] <= input_data;
        if (x_we) x_mem[wr_idx[RW-1:0]] <= input_data;
    end

endmodule

// File: tb/tb_matvec_param.sv
module tb_matvec_param;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic               in_valid, new_matrix, out_ready;
    logic signed [13:0] in_data;
    logic               in_ready, out_valid, out_last, out_sat;
    logic signed [27:0] out_data;
    logic               in_ready0, out_valid0, out_last0, out_sat0;
    logic signed [27:0] out_data0;

    int errors = 0;
    int checks = 0;

    matvec_param #(.N(3), .IW(14), .OW(28), .SATURATE(1)) dut (
        .clk(clk), .reset(reset),
        .input_valid(in_valid), .input_ready(in_ready), .input_data(in_data),
        .new_matrix(new_matrix),
        .output_valid(out_valid), .output_ready(out_ready), .output_data(out_data),
        .output_last(out_last), .output_sat(out_sat)
    );

    matvec_param #(.N(3), .IW(14), .OW(28), .SATURATE(0)) dut0 (
        .clk(clk), .reset(reset),
        .input_valid(in_valid), .input_ready(in_ready0), .input_data(in_data),
        .new_matrix(new_matrix),
        .output_valid(out_valid0), .output_ready(out_ready), .output_data(out_data0),
        .output_last(out_last0), .output_sat(out_sat0)
    );

    typedef struct {
        bit nm;
        bit hold;
        int w[9];
        int x[3];
        int ys[3];   // expected y, saturating instance
        int yw[3];   // expected y, wrapping instance
        bit sf[3];   // expected output_sat, saturating instance
    } vec_t;

    vec_t tab[6];

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Present one element and hold it until accepted; returns 1ns after the accepting edge.
    task automatic send(input int d, input logic nm);
        int n = 0;
        in_valid   = 1'b1;
        in_data    = d[13:0];
        new_matrix = nm;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("send_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Later beats carry the inverted new_matrix to show it is ignored after the first beat.
    task automatic run_tx(input int v, input logic nm, input bit send_w, input bit chk_ready);
        int b = 0;
        if (send_w) begin
            for (int i = 0; i < 9; i++) begin
                send(tab[v].w[i], (b == 0) ? nm : ~nm);
                b++;
                if (i == 4) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (chk_ready && i == 2) begin
                chk("pre_last_ready", in_ready, 1);
                chk("pre_last_valid", out_valid, 0);
            end
            send(tab[v].x[i], (b == 0) ? nm : ~nm);
            b++;
        end
    endtask

    task automatic recv(input int v, input bit hold);
        for (int r = 0; r < 3; r++) begin
            int cyc = 0;
            while (!out_valid && cyc < 100) begin
                @(posedge clk);
                #1;
                cyc++;
            end
            chk($sformatf("v%0d_r%0d_latency", v, r), cyc, 4);
            if (hold && r == 0) begin
                for (int h = 0; h < 5; h++) begin
                    @(posedge clk);
                    #1;
                    chk($sformatf("v%0d_hold%0d_data", v, h), out_data, tab[v].ys[0]);
                    chk($sformatf("v%0d_hold%0d_valid", v, h), out_valid, 1);
                    chk($sformatf("v%0d_hold%0d_in_ready", v, h), in_ready, 0);
                end
            end
            chk($sformatf("v%0d_r%0d_data", v, r), out_data, tab[v].ys[r]);
            chk($sformatf("v%0d_r%0d_sat", v, r), out_sat, tab[v].sf[r]);
            chk($sformatf("v%0d_r%0d_last", v, r), out_last, (r == 2));
            chk($sformatf("v%0d_r%0d_valid_wrap", v, r), out_valid0, 1);
            chk($sformatf("v%0d_r%0d_data_wrap", v, r), out_data0, tab[v].yw[r]);
            chk($sformatf("v%0d_r%0d_sat_wrap", v, r), out_sat0, 0);
            chk($sformatf("v%0d_r%0d_last_wrap", v, r), out_last0, (r == 2));
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
        end
        chk($sformatf("v%0d_end_in_ready", v), in_ready, 1);
        chk($sformatf("v%0d_end_valid", v), out_valid, 0);
    endtask

    initial begin
        // 0: W=1..9, x=[1,2,3]
        tab[0].nm = 1; tab[0].hold = 0;
        tab[0].w  = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        tab[0].x  = '{1, 2, 3};
        tab[0].ys = '{14, 32, 50}; tab[0].yw = '{14, 32, 50}; tab[0].sf = '{0, 0, 0};
        // 1: reuse W=1..9, x=[-1,0,1]
        tab[1].nm = 0; tab[1].hold = 0;
        tab[1].w  = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        tab[1].x  = '{-1, 0, 1};
        tab[1].ys = '{2, 2, 2}; tab[1].yw = '{2, 2, 2}; tab[1].sf = '{0, 0, 0};
        // 2: all -8192: 3*2^26 clamps positive / wraps negative
        tab[2].nm = 1; tab[2].hold = 0;
        tab[2].w  = '{-8192, -8192, -8192, -8192, -8192, -8192, -8192, -8192, -8192};
        tab[2].x  = '{-8192, -8192, -8192};
        tab[2].ys = '{134217727, 134217727, 134217727};
        tab[2].yw = '{-67108864, -67108864, -67108864};
        tab[2].sf = '{1, 1, 1};
        // 3: mixed signs, held output on row 0
        tab[3].nm = 1; tab[3].hold = 1;
        tab[3].w  = '{2, -3, 0, 0, 1, 5, -7, 4, 1};
        tab[3].x  = '{10, -20, 30};
        tab[3].ys = '{80, 130, -120}; tab[3].yw = '{80, 130, -120}; tab[3].sf = '{0, 0, 0};
        // 4: reuse W of 3 with extreme x
        tab[4].nm = 0; tab[4].hold = 0;
        tab[4].w  = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        tab[4].x  = '{8191, -8192, 1};
        tab[4].ys = '{40958, -8187, -90104}; tab[4].yw = '{40958, -8187, -90104}; tab[4].sf = '{0, 0, 0};
        // 5: all W=8191, x=-8192: clamps negative / wraps positive
        tab[5].nm = 1; tab[5].hold = 0;
        tab[5].w  = '{8191, 8191, 8191, 8191, 8191, 8191, 8191, 8191, 8191};
        tab[5].x  = '{-8192, -8192, -8192};
        tab[5].ys = '{-134217728, -134217728, -134217728};
        tab[5].yw = '{67133440, 67133440, 67133440};
        tab[5].sf = '{1, 1, 1};

        reset = 1'b1; in_valid = 1'b0; in_data = '0; new_matrix = 1'b0; out_ready = 1'b0;
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_last", out_last, 0);
        chk("rst_sat", out_sat, 0);
        chk("rst_in_ready_wrap", in_ready0, 1);
        chk("rst_valid_wrap", out_valid0, 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int v = 0; v < 6; v++) begin
            run_tx(v, tab[v].nm, tab[v].nm, 1'b0);
            recv(v, tab[v].hold);
        end

        // Reset while computing, then a new_matrix=0 transaction must still load W.
        run_tx(0, 1'b1, 1'b1, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("compute_in_ready", in_ready, 0);
        reset = 1'b1;
        #1;
        chk("rst_compute_in_ready", in_ready, 1);
        chk("rst_compute_valid", out_valid, 0);
        chk("rst_compute_in_ready_wrap", in_ready0, 1);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        run_tx(3, 1'b0, 1'b1, 1'b1);
        recv(3, 1'b0);

        // Reset during a partial W load discards it.
        for (int i = 0; i < 5; i++) send(tab[0].w[i], (i == 0));
        reset = 1'b1;
        #1;
        chk("rst_partial_in_ready", in_ready, 1);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        run_tx(0, 1'b0, 1'b1, 1'b1);
        recv(0, 1'b0);

        // Reset while a row is being offered drops valid and clears the output register.
        run_tx(1, 1'b0, 1'b0, 1'b0);
        begin
            int cyc = 0;
            while (!out_valid && cyc < 100) begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        chk("pre_rst_out_valid", out_valid, 1);
        chk("pre_rst_out_data", out_data, 2);
        reset = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_in_ready", in_ready, 1);
        chk("rst_out_valid_wrap", out_valid0, 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
